// File: rtl/eth_tx_scheduler_pkg.sv
// rtl/eth_tx_scheduler_pkg.sv - shared state/grant encodings and defaults for eth_tx_scheduler
//
// Package eth_tx_sched_defs:
//   DATA_WIDTH_DEF  : default word width of FIFO, status and ethernet data
//   FLUSH_WORDS_DEF : default push count that forces a flush
//   state_t         : scheduler FSM states
//   grant_t         : which requester received the most recent push
package eth_tx_sched_defs;

    localparam int DATA_WIDTH_DEF  = 48;
    localparam int FLUSH_WORDS_DEF = 32;

    typedef enum logic [2:0] {
        IDLE        = 3'd0,
        FIFO_RD     = 3'd1,
        FIFO_WAIT   = 3'd2,
        PUSH_SAMPLE = 3'd3,
        PUSH_STATUS = 3'd4,
        FLUSH       = 3'd5
    } state_t;

    typedef enum logic {
        GRANT_SAMPLE = 1'b0,
        GRANT_STATUS = 1'b1
    } grant_t;

endpackage

// File: rtl/eth_tx_flush_policy.sv
// rtl/eth_tx_flush_policy.sv - pending-word counter and flush decision for eth_tx_scheduler
//
// Optional feature macro: ETH_TX_SCHED_TIMEOUT_FLUSH_EN (idle timeout flush).
//
// Ports:
//   clk, rst_n     : clock, asynchronous active-low reset
//   push           : a word is pushed to ethernet at this edge
//   flush          : a flush is issued at this edge
//   idle_wait      : scheduler sits in IDLE this cycle without granting anything
//   words_pending  : words pushed since the last flush (saturates at FLUSH_WORDS)
//   at_limit       : words_pending == FLUSH_WORDS, no further push may be granted
//   flush_due      : a flush should be taken as soon as ethernet is available
module eth_tx_flush_policy #(
    parameter int FLUSH_WORDS    = 32,
    parameter int TIMEOUT_CYCLES = 50000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       push,
    input  logic       flush,
    input  logic       idle_wait,
    output logic [7:0] words_pending,
    output logic       at_limit,
    output logic       flush_due
);

    localparam logic [7:0] LIMIT = 8'(FLUSH_WORDS);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            words_pending <= 8'd0;
        end else if (flush) begin
            words_pending <= 8'd0;
        end else if (push && (words_pending != LIMIT)) begin
            words_pending <= words_pending + 8'd1;
        end
    end

    assign at_limit = (words_pending == LIMIT);

`ifdef ETH_TX_SCHED_TIMEOUT_FLUSH_EN
    localparam int              TW      = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TW-1:0]   TO_LAST = TW'(TIMEOUT_CYCLES - 1);

    logic [TW-1:0] idle_cnt;

    // Holds at TO_LAST while ethernet is busy so the flush fires once it frees up.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idle_cnt <= '0;
        end else if (push || flush) begin
            idle_cnt <= '0;
        end else if (idle_wait && (words_pending != 8'd0) && (idle_cnt != TO_LAST)) begin
            idle_cnt <= idle_cnt + 1'b1;
        end
    end

    assign flush_due = at_limit || ((words_pending != 8'd0) && (idle_cnt == TO_LAST));
`else
    logic unused_policy_in;
    assign unused_policy_in = idle_wait | (TIMEOUT_CYCLES > 0);

    assign flush_due = at_limit;
`endif

endmodule

// File: rtl/eth_tx_scheduler.sv
// rtl/eth_tx_scheduler.sv - arbitrates FIFO samples and status words into the wiznet5500 TX path
//
// Optional feature macro: ETH_TX_SCHED_TIMEOUT_FLUSH_EN (idle timeout flush, see eth_tx_flush_policy).
//
// Ports:
//   clk, rst_n           : 50 MHz clock, asynchronous active-low reset
//   fifo_empty           : sample FIFO empty flag
//   fifo_read_enabled    : one-cycle FIFO read strobe
//   fifo_data_out        : FIFO read data
//   fifo_data_out_valid  : FIFO data valid, one cycle after the read strobe
//   status_word          : status payload, stable while status_valid
//   status_valid         : status request level, held until status_ack
//   status_ack           : one-cycle pulse coinciding with the status push
//   eth_available        : wiznet5500 ready
//   eth_data             : wiznet5500 data input (holds between pushes)
//   eth_data_valid       : one-cycle push strobe
//   eth_flush            : one-cycle flush strobe
//   words_pending        : words pushed since the last flush
module eth_tx_scheduler
    import eth_tx_sched_defs::*;
#(
    parameter int DATA_WIDTH     = DATA_WIDTH_DEF,
    parameter int FLUSH_WORDS    = FLUSH_WORDS_DEF,
    parameter int TIMEOUT_CYCLES = 50000
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  fifo_empty,
    output logic                  fifo_read_enabled,
    input  logic [DATA_WIDTH-1:0] fifo_data_out,
    input  logic                  fifo_data_out_valid,
    input  logic [DATA_WIDTH-1:0] status_word,
    input  logic                  status_valid,
    output logic                  status_ack,
    input  logic                  eth_available,
    output logic [DATA_WIDTH-1:0] eth_data,
    output logic                  eth_data_valid,
    output logic                  eth_flush,
    output logic [7:0]            words_pending
);

    state_t                state;
    grant_t                last_grant;
    logic [DATA_WIDTH-1:0] sample_buf;
    logic                  buf_valid;

    logic at_limit;
    logic flush_due;

    // status_valid is still high in the cycle the source first sees status_ack,
    // so a request is ignored while our own ack is on the wire.
    logic status_req;
    logic in_idle;
    logic take_flush;
    logic take_status;
    logic take_fifo;
    logic idle_wait;
    logic push_sample;
    logic push_status;

    assign status_req  = status_valid && !status_ack;
    assign in_idle     = (state == IDLE);
    assign take_flush  = in_idle && flush_due && eth_available;
    assign take_status = in_idle && !take_flush && !at_limit && status_req &&
                         ((last_grant == GRANT_SAMPLE) || fifo_empty);
    assign take_fifo   = in_idle && !take_flush && !at_limit && !take_status && !fifo_empty;
    assign idle_wait   = in_idle && !take_flush && !take_status && !take_fifo;
    assign push_sample = (state == PUSH_SAMPLE) && eth_available && buf_valid;
    assign push_status = (state == PUSH_STATUS) && eth_available;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state             <= IDLE;
            last_grant        <= GRANT_SAMPLE;
            sample_buf        <= '0;
            buf_valid         <= 1'b0;
            fifo_read_enabled <= 1'b0;
            eth_data          <= '0;
            eth_data_valid    <= 1'b0;
            status_ack        <= 1'b0;
            eth_flush         <= 1'b0;
        end else begin
            fifo_read_enabled <= 1'b0;
            eth_data_valid    <= 1'b0;
            status_ack        <= 1'b0;
            eth_flush         <= 1'b0;
            case (state)
                IDLE: begin
                    if (take_flush) begin
                        state <= FLUSH;
                    end else if (take_status) begin
                        state <= PUSH_STATUS;
                    end else if (take_fifo) begin
                        state             <= FIFO_RD;
                        fifo_read_enabled <= 1'b1;
                    end
                end
                FIFO_RD: begin
                    state <= FIFO_WAIT;
                end
                FIFO_WAIT: begin
                    // No timeout and no second strobe: the FIFO always answers a read.
                    if (fifo_data_out_valid) begin
                        sample_buf <= fifo_data_out;
                        buf_valid  <= 1'b1;
                        state      <= PUSH_SAMPLE;
                    end
                end
                PUSH_SAMPLE: begin
                    if (push_sample) begin
                        eth_data       <= sample_buf;
                        eth_data_valid <= 1'b1;
                        buf_valid      <= 1'b0;
                        last_grant     <= GRANT_SAMPLE;
                        state          <= IDLE;
                    end
                end
                PUSH_STATUS: begin
                    if (push_status) begin
                        eth_data       <= status_word;
                        eth_data_valid <= 1'b1;
                        status_ack     <= 1'b1;
                        last_grant     <= GRANT_STATUS;
                        state          <= IDLE;
                    end
                end
                FLUSH: begin
                    eth_flush <= 1'b1;
                    state     <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    eth_tx_flush_policy #(
        .FLUSH_WORDS    (FLUSH_WORDS),
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_flush_policy (
        .clk           (clk),
        .rst_n         (rst_n),
        .push          (push_sample || push_status),
        .flush         (state == FLUSH),
        .idle_wait     (idle_wait),
        .words_pending (words_pending),
        .at_limit      (at_limit),
        .flush_due     (flush_due)
    );

endmodule

// File: tb/tb_eth_tx_scheduler.sv
// tb/tb_eth_tx_scheduler.sv - directed vector bench for eth_tx_scheduler
module tb_eth_tx_scheduler;

    localparam int DW      = 48;
    localparam int TIMEOUT = 16;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          fifo_empty = 1'b1;
    logic          fifo_read_enabled;
    logic [DW-1:0] fifo_data_out = '0;
    logic          fifo_data_out_valid = 1'b0;
    logic [DW-1:0] status_word = '0;
    logic          status_valid = 1'b0;
    logic          status_ack;
    logic          eth_available = 1'b0;
    logic [DW-1:0] eth_data;
    logic          eth_data_valid;
    logic          eth_flush;
    logic [7:0]    words_pending;

    always #10 clk = ~clk;

    eth_tx_scheduler #(
        .DATA_WIDTH     (DW),
        .FLUSH_WORDS    (32),
        .TIMEOUT_CYCLES (TIMEOUT)
    ) dut (
        .clk                 (clk),
        .rst_n               (rst_n),
        .fifo_empty          (fifo_empty),
        .fifo_read_enabled   (fifo_read_enabled),
        .fifo_data_out       (fifo_data_out),
        .fifo_data_out_valid (fifo_data_out_valid),
        .status_word         (status_word),
        .status_valid        (status_valid),
        .status_ack          (status_ack),
        .eth_available       (eth_available),
        .eth_data            (eth_data),
        .eth_data_valid      (eth_data_valid),
        .eth_flush           (eth_flush),
        .words_pending       (words_pending)
    );

    typedef struct {
        logic          fe;
        logic          fdv;
        logic [DW-1:0] fd;
        logic          sv;
        logic [DW-1:0] sw;
        logic          ea;
        logic          rd;
        logic          edv;
        logic [DW-1:0] ed;
        logic          ack;
        logic          fl;
        logic [7:0]    wp;
    } vec_t;

    int n_vec = 0;
    int n_err = 0;

    // FIFO / sink model state
    bit            model_on = 0;
    bit            pend = 0;
    logic [DW-1:0] fq[$];
    logic [DW-1:0] got_q[$];
    logic          got_ack[$];
    int            n_flush, flush_push_idx, wp_over, both_err, rd_seen;
    logic [7:0]    wp_prev, flush_wp_before, flush_wp_after;

    function automatic vec_t mk(input logic fe, input logic fdv, input logic [DW-1:0] fd,
                                input logic sv, input logic [DW-1:0] sw, input logic ea,
                                input logic rd, input logic edv, input logic [DW-1:0] ed,
                                input logic ack, input logic fl, input logic [7:0] wp);
        vec_t v;
        v.fe = fe; v.fdv = fdv; v.fd = fd; v.sv = sv; v.sw = sw; v.ea = ea;
        v.rd = rd; v.edv = edv; v.ed = ed; v.ack = ack; v.fl = fl; v.wp = wp;
        return v;
    endfunction

    function automatic logic [63:0] outs();
        return {4'b0, fifo_read_enabled, eth_data_valid, eth_data, status_ack, eth_flush, words_pending};
    endfunction

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", name, got, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
        if (eth_data_valid) begin
            got_q.push_back(eth_data);
            got_ack.push_back(status_ack);
        end
        if (fifo_read_enabled) rd_seen++;
        if (eth_flush) begin
            n_flush++;
            flush_push_idx  = got_q.size();
            flush_wp_before = wp_prev;
            flush_wp_after  = words_pending;
            if (eth_data_valid) both_err++;
        end
        if (words_pending > 8'd32) wp_over++;
        wp_prev = words_pending;
        if (model_on) begin
            fifo_data_out_valid = pend;
            if (pend && fq.size() > 0) fifo_data_out = fq.pop_front();
            pend = fifo_read_enabled;
            fifo_empty = (fq.size() == 0);
        end
    endtask

    task automatic reset_dut(input bit use_model);
        rst_n = 1'b0;
        model_on = use_model;
        pend = 0;
        fifo_data_out_valid = 1'b0;
        fifo_data_out = '0;
        fifo_empty = 1'b1;
        status_valid = 1'b0;
        status_word = '0;
        fq.delete(); got_q.delete(); got_ack.delete();
        n_flush = 0; flush_push_idx = 0; wp_over = 0; both_err = 0; rd_seen = 0;
        wp_prev = '0; flush_wp_before = '0; flush_wp_after = '0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t           tbl[$];
        int             k;
        int             bad;
        logic [DW-1:0]  w1, w2, w3;
        logic [5:0]     order;
        localparam logic [DW-1:0] A  = 48'h1111_0000_00A1;
        localparam logic [DW-1:0] B  = 48'h2222_0000_00B2;
        localparam logic [DW-1:0] S1 = 48'h5555_0000_0001;
        localparam logic [DW-1:0] S2 = 48'h5555_0000_0002;
        localparam logic [DW-1:0] S3 = 48'h5555_0000_0003;

        // ---------------- table-driven cycle vectors ----------------
        //               fe fdv fd sv sw  ea | rd edv ed  ack fl wp
        tbl.push_back(mk(0, 0, 0, 0, 0,  1,   1, 0, 0,  0, 0, 0));
        tbl.push_back(mk(0, 0, 0, 0, 0,  1,   0, 0, 0,  0, 0, 0));
        tbl.push_back(mk(0, 1, A, 0, 0,  1,   0, 0, 0,  0, 0, 0));
        tbl.push_back(mk(1, 0, 0, 0, 0,  0,   0, 0, 0,  0, 0, 0));
        tbl.push_back(mk(1, 0, 0, 0, 0,  1,   0, 1, A,  0, 0, 1));
        tbl.push_back(mk(0, 0, 0, 1, S1, 1,   0, 0, A,  0, 0, 1));
        tbl.push_back(mk(0, 0, 0, 1, S1, 1,   0, 1, S1, 1, 0, 2));
        tbl.push_back(mk(1, 0, 0, 1, S1, 1,   0, 0, S1, 0, 0, 2));
        tbl.push_back(mk(0, 0, 0, 1, S2, 1,   1, 0, S1, 0, 0, 2));
        tbl.push_back(mk(0, 0, 0, 1, S2, 1,   0, 0, S1, 0, 0, 2));
        tbl.push_back(mk(0, 1, B, 1, S2, 1,   0, 0, S1, 0, 0, 2));
        tbl.push_back(mk(0, 0, 0, 1, S2, 1,   0, 1, B,  0, 0, 3));
        tbl.push_back(mk(0, 0, 0, 1, S2, 1,   0, 0, B,  0, 0, 3));
        tbl.push_back(mk(0, 0, 0, 1, S2, 1,   0, 1, S2, 1, 0, 4));
        tbl.push_back(mk(1, 0, 0, 0, 0,  1,   0, 0, S2, 0, 0, 4));
        tbl.push_back(mk(1, 0, 0, 1, S3, 1,   0, 0, S2, 0, 0, 4));
        tbl.push_back(mk(1, 0, 0, 1, S3, 0,   0, 0, S2, 0, 0, 4));
        tbl.push_back(mk(1, 0, 0, 1, S3, 1,   0, 1, S3, 1, 0, 5));
        tbl.push_back(mk(1, 0, 0, 0, 0,  1,   0, 0, S3, 0, 0, 5));

        eth_available = 1'b1;
        rst_n = 1'b0;
        @(negedge clk);
        check("reset_outputs", outs(), 64'd0);
        reset_dut(0);
        for (int i = 0; i < tbl.size(); i++) begin
            fifo_empty          = tbl[i].fe;
            fifo_data_out_valid = tbl[i].fdv;
            fifo_data_out       = tbl[i].fd;
            status_valid        = tbl[i].sv;
            status_word         = tbl[i].sw;
            eth_available       = tbl[i].ea;
            @(negedge clk);
            check($sformatf("vec%0d", i), outs(),
                  {4'b0, tbl[i].rd, tbl[i].edv, tbl[i].ed, tbl[i].ack, tbl[i].fl, tbl[i].wp});
        end

        // ---------------- count flush with 40 preloaded words ----------------
        reset_dut(1);
        eth_available = 1'b1;
        for (int i = 0; i < 40; i++) fq.push_back(48'h0A00_0000_0000 + 48'(i));
        fifo_empty = 1'b0;
        k = 0;
        while (got_q.size() < 40 && k < 400) begin tick(); k++; end
        check("cnt_all_pushed", 64'(got_q.size()), 64'd40);
        check("cnt_flush_count", 64'(n_flush), 64'd1);
        check("cnt_flush_after_32", 64'(flush_push_idx), 64'd32);
        check("cnt_wp_before_flush", 64'(flush_wp_before), 64'd32);
        check("cnt_wp_after_flush", 64'(flush_wp_after), 64'd0);
        check("cnt_wp_final", 64'(words_pending), 64'd8);
        check("cnt_no_overflow", 64'(wp_over), 64'd0);
        check("cnt_no_push_with_flush", 64'(both_err), 64'd0);
        bad = 0;
        for (int i = 0; i < got_q.size(); i++)
            if (got_q[i] !== 48'h0A00_0000_0000 + 48'(i)) bad++;
        check("cnt_fifo_order", 64'(bad), 64'd0);

        // ---------------- back-pressure in PUSH_SAMPLE ----------------
        reset_dut(1);
        eth_available = 1'b0;
        fq.push_back(48'hB0B0_B0B0_B0B0);
        fifo_empty = 1'b0;
        repeat (6) tick();
        rd_seen = 0;
        repeat (100) tick();
        check("bp_no_push", 64'(got_q.size()), 64'd0);
        check("bp_no_read", 64'(rd_seen), 64'd0);
        eth_available = 1'b1;
        tick();
        check("bp_push_next_cycle", {15'd0, eth_data_valid, eth_data}, {15'd0, 1'b1, 48'hB0B0_B0B0_B0B0});

        // ---------------- arbitration with status held high ----------------
        reset_dut(1);
        eth_available = 1'b1;
        for (int i = 0; i < 5; i++) fq.push_back(48'hF000_0000_0000 + 48'(i));
        fifo_empty   = 1'b0;
        status_valid = 1'b1;
        status_word  = 48'h5A00_0000_0001;
        k = 0;
        while (got_q.size() < 6 && k < 200) begin
            tick();
            k++;
            if (status_ack) begin
                check("arb_ack_data", {15'd0, eth_data_valid, eth_data}, {15'd0, 1'b1, status_word});
                status_word = status_word + 48'd1;
            end
        end
        order = '0;
        for (int i = 0; i < 6 && i < got_q.size(); i++) order[5-i] = got_ack[i];
        check("arb_grant_order", 64'(order), 64'b101010);
        check("arb_sample_data", {16'd0, (got_q.size() > 3) ? got_q[3] : 48'd0}, 64'h0000_F000_0000_0001);
        status_valid = 1'b0;

        // ---------------- reset during FIFO_WAIT ----------------
        reset_dut(1);
        eth_available = 1'b1;
        w1 = 48'h0000_0D0E_AD01; w2 = 48'h0000_0D0E_AD02; w3 = 48'h0000_0D0E_AD03;
        fq.push_back(w1); fq.push_back(w2);
        fifo_empty = 1'b0;
        k = 0;
        while (got_q.size() < 1 && k < 20) begin tick(); k++; end
        k = 0;
        while (!fifo_read_enabled && k < 20) begin tick(); k++; end
        tick();
        check("rst_wait_valid_present", 64'(fifo_data_out_valid), 64'd1);
        rst_n = 1'b0;
        #1;
        check("rst_mid_outputs", outs(), 64'd0);
        tick();
        rst_n = 1'b1;
        rd_seen = 0;
        repeat (20) tick();
        check("rst_no_push_after", 64'(got_q.size()), 64'd1);
        check("rst_no_read_after", 64'(rd_seen), 64'd0);
        fq.push_back(w3);
        fifo_empty = 1'b0;
        k = 0;
        while (got_q.size() < 2 && k < 20) begin tick(); k++; end
        check("rst_new_word", {16'd0, (got_q.size() > 1) ? got_q[1] : 48'd0}, {16'd0, w3});

        // ---------------- partial packet: timeout or none ----------------
        reset_dut(1);
        eth_available = 1'b1;
        for (int i = 0; i < 3; i++) fq.push_back(48'h0C00_0000_0000 + 48'(i));
        fifo_empty = 1'b0;
        k = 0;
        while (got_q.size() < 3 && k < 50) begin tick(); k++; end
        k = 0;
        while (n_flush == 0 && k < 1000) begin tick(); k++; end
`ifdef ETH_TX_SCHED_TIMEOUT_FLUSH_EN
        check("to_flush_count", 64'(n_flush), 64'd1);
        check("to_flush_latency", 64'(k), 64'(TIMEOUT + 1));
        check("to_wp_before_flush", 64'(flush_wp_before), 64'd3);
`else
        check("nto_no_flush", 64'(n_flush), 64'd0);
        check("nto_wp_held", 64'(words_pending), 64'd3);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
